// File: rtl/cv32e40px_rf_wb_arbiter.sv
// Register-file write port B arbiter: the LSU writes combinationally with absolute priority,
// and X-interface results are buffered and issued as single, pair, or split dual writes.
module cv32e40px_rf_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned X_DUALWRITE = 0,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  lsu_we_i,
  input  logic [ADDR_WIDTH-1:0]                 lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]                 lsu_wdata_i,
  input  logic                                  x_result_valid_i,
  output logic                                  x_result_ready_o,
  input  logic [ADDR_WIDTH-1:0]                 x_result_rd_i,
  input  logic                                  x_result_we_i,
  input  logic                                  x_result_dualwrite_i,
  input  logic [2*DATA_WIDTH-1:0]               x_result_data_i,
  output logic [ADDR_WIDTH-1:0]                 waddr_b_o,
  output logic [(X_DUALWRITE+1)*DATA_WIDTH-1:0] wdata_b_o,
  output logic [X_DUALWRITE:0]                  we_b_o,
  output logic                                  pending_o,
  output logic                                  err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [0:0] ISSUE  = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;
  localparam logic [ADDR_WIDTH-2:0] LOW_MAX = '1;
  localparam logic [ADDR_WIDTH-2:0] LOW_ONE = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};

  logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [0:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_q   [DEPTH];
  logic [ADDR_WIDTH-1:0]   rd_d   [DEPTH];
  logic [2*DATA_WIDTH-1:0] data_q [DEPTH];
  logic [2*DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]        dual_q, dual_d;

  logic                    push, pop;
  logic [ADDR_WIDTH-1:0]   head_rd;
  logic [2*DATA_WIDTH-1:0] head_data;
  logic                    head_dual;
  logic [ADDR_WIDTH-2:0]   head_low_inc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign x_result_ready_o = (count_q != CNT_W'(DEPTH));
  assign pending_o        = (count_q != '0) | (state_q == SECOND);
  assign push             = x_result_valid_i & x_result_ready_o & x_result_we_i;

  assign head_rd      = rd_q[rptr_q];
  assign head_data    = data_q[rptr_q];
  assign head_dual    = dual_q[rptr_q];
  assign head_low_inc = head_rd[ADDR_WIDTH-2:0] + LOW_ONE;

  // Issue selection; the LSU is gated by reset so outputs are zero while in reset.
  always_comb begin
    we_b_o    = '0;
    waddr_b_o = '0;
    wdata_b_o = '0;
    err_o     = 1'b0;
    pop       = 1'b0;
    state_d   = state_q;
    if (lsu_we_i && rst_n) begin
      we_b_o[0]                  = 1'b1;
      waddr_b_o                  = lsu_waddr_i;
      wdata_b_o[DATA_WIDTH-1:0]  = lsu_wdata_i;
    end else if (count_q != '0) begin
      we_b_o[0] = 1'b1;
      if (state_q == SECOND) begin
        waddr_b_o                 = {head_rd[ADDR_WIDTH-1], head_low_inc};
        wdata_b_o[DATA_WIDTH-1:0] = head_data[2*DATA_WIDTH-1:DATA_WIDTH];
        pop                       = 1'b1;
        state_d                   = ISSUE;
      end else begin
        waddr_b_o                 = head_rd;
        wdata_b_o[DATA_WIDTH-1:0] = head_data[DATA_WIDTH-1:0];
        if (!head_dual) begin
          pop = 1'b1;
        end else if (head_rd[ADDR_WIDTH-2:0] == LOW_MAX) begin
          pop   = 1'b1;
          err_o = 1'b1;
        end else if ((X_DUALWRITE != 0) && !head_rd[0]) begin
          we_b_o = '1;
          wdata_b_o[(X_DUALWRITE+1)*DATA_WIDTH-1 -: DATA_WIDTH] =
            head_data[2*DATA_WIDTH-1:DATA_WIDTH];
          pop = 1'b1;
        end else begin
          state_d = SECOND;
        end
      end
    end
  end

  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    dual_d = dual_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    count_d = count_q;
    if (push) begin
      rd_d[wptr_q]   = x_result_rd_i;
      data_d[wptr_q] = x_result_data_i;
      dual_d[wptr_q] = x_result_dualwrite_i;
      wptr_d         = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= ISSUE;
      dual_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
      dual_q  <= dual_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_cv32e40px_rf_wb_arbiter.sv
// Directed bench for the port B arbiter: a pair-capable instance and a split-only
// instance share the same stimulus.
module tb_cv32e40px_rf_wb_arbiter;

  logic        clk, rst_n;
  logic        lsu_we;
  logic [5:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        xv, xwe, xdual;
  logic [5:0]  xrd;
  logic [63:0] xdata;

  logic        ready1, pend1, err1;
  logic [5:0]  waddr1;
  logic [63:0] wdata1;
  logic [1:0]  we1;
  logic        ready0, pend0, err0;
  logic [5:0]  waddr0;
  logic [31:0] wdata0;
  logic [0:0]  we0;

  int n_run = 0;
  int n_fail = 0;

  cv32e40px_rf_wb_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .X_DUALWRITE(1), .DEPTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .x_result_valid_i(xv), .x_result_ready_o(ready1), .x_result_rd_i(xrd),
    .x_result_we_i(xwe), .x_result_dualwrite_i(xdual), .x_result_data_i(xdata),
    .waddr_b_o(waddr1), .wdata_b_o(wdata1), .we_b_o(we1), .pending_o(pend1), .err_o(err1)
  );

  cv32e40px_rf_wb_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .X_DUALWRITE(0), .DEPTH(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .x_result_valid_i(xv), .x_result_ready_o(ready0), .x_result_rd_i(xrd),
    .x_result_we_i(xwe), .x_result_dualwrite_i(xdual), .x_result_data_i(xdata),
    .waddr_b_o(waddr0), .wdata_b_o(wdata0), .we_b_o(we0), .pending_o(pend0), .err_o(err0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_x(input logic [5:0] rd, input logic dual, input logic we,
                         input logic [31:0] d1, input logic [31:0] d0);
    xv = 1'b1; xrd = rd; xdual = dual; xwe = we; xdata = {d1, d0};
  endtask

  task automatic clear_x();
    xv = 1'b0; xrd = '0; xdual = 1'b0; xwe = 1'b0; xdata = '0;
  endtask

  task automatic test_reset();
    lsu_we = 1'b1; lsu_waddr = 6'd3; lsu_wdata = 32'h1234;
    #3;
    n_run++; if ({we1, waddr1, wdata1} !== 72'h0) begin n_fail++; $display("FAIL reset_port1 got %h exp 0", {we1, waddr1, wdata1}); end
    n_run++; if ({we0, waddr0, wdata0} !== 39'h0) begin n_fail++; $display("FAIL reset_port0 got %h exp 0", {we0, waddr0, wdata0}); end
    n_run++; if ({ready1, pend1, err1} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got %b exp 100", {ready1, pend1, err1}); end
    lsu_we = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive_x(6'd5, 1'b0, 1'b1, 32'h0, 32'hA5A5_0001);
    @(negedge clk);
    n_run++; if ({ready1, we1} !== 3'b100) begin n_fail++; $display("FAIL single_accept got %b exp 100", {ready1, we1}); end
    tick(); clear_x();
    @(negedge clk);
    n_run++; if ({we1, waddr1, wdata1} !== {2'b01, 6'd5, 64'h0000_0000_A5A5_0001}) begin n_fail++; $display("FAIL single_write got %h", {we1, waddr1, wdata1}); end
    n_run++; if (pend1 !== 1'b1) begin n_fail++; $display("FAIL single_pend_hi got %b exp 1", pend1); end
    tick();
    @(negedge clk);
    n_run++; if ({pend1, we1, pend0, we0} !== 5'b0) begin n_fail++; $display("FAIL single_idle got %b exp 0", {pend1, we1, pend0, we0}); end
    tick();
  endtask

  task automatic test_pair();
    drive_x(6'd6, 1'b1, 1'b1, 32'h2, 32'h1);
    tick(); clear_x();
    @(negedge clk);
    n_run++; if ({we1, waddr1, wdata1} !== {2'b11, 6'd6, 64'h0000_0002_0000_0001}) begin n_fail++; $display("FAIL pair_write got %h", {we1, waddr1, wdata1}); end
    n_run++; if ({we0, waddr0, wdata0} !== {1'b1, 6'd6, 32'h1}) begin n_fail++; $display("FAIL pair_split0_first got %h", {we0, waddr0, wdata0}); end
    tick();
    @(negedge clk);
    n_run++; if ({we1, pend1} !== 3'b000) begin n_fail++; $display("FAIL pair_done got %b exp 000", {we1, pend1}); end
    n_run++; if ({we0, waddr0, wdata0, pend0} !== {1'b1, 6'd7, 32'h2, 1'b1}) begin n_fail++; $display("FAIL pair_split0_second got %h", {we0, waddr0, wdata0, pend0}); end
    tick();
    @(negedge clk);
    n_run++; if ({we0, pend0} !== 2'b00) begin n_fail++; $display("FAIL pair_split0_done got %b exp 00", {we0, pend0}); end
    tick();
  endtask

  task automatic test_split_lsu();
    drive_x(6'd7, 1'b1, 1'b1, 32'h2, 32'h1);
    tick(); clear_x();
    @(negedge clk);
    n_run++; if ({we1, waddr1, wdata1} !== {2'b01, 6'd7, 64'h1}) begin n_fail++; $display("FAIL split_first got %h", {we1, waddr1, wdata1}); end
    n_run++; if ({we0, waddr0, wdata0} !== {1'b1, 6'd7, 32'h1}) begin n_fail++; $display("FAIL split0_first got %h", {we0, waddr0, wdata0}); end
    tick();
    lsu_we = 1'b1; lsu_waddr = 6'd3; lsu_wdata = 32'hDEAD;
    @(negedge clk);
    n_run++; if ({we1, waddr1, wdata1, pend1} !== {2'b01, 6'd3, 64'hDEAD, 1'b1}) begin n_fail++; $display("FAIL split_lsu got %h", {we1, waddr1, wdata1, pend1}); end
    n_run++; if ({we0, waddr0, wdata0} !== {1'b1, 6'd3, 32'hDEAD}) begin n_fail++; $display("FAIL split0_lsu got %h", {we0, waddr0, wdata0}); end
    tick();
    lsu_we = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    @(negedge clk);
    n_run++; if ({we1, waddr1, wdata1} !== {2'b01, 6'd8, 64'h2}) begin n_fail++; $display("FAIL split_second got %h", {we1, waddr1, wdata1}); end
    n_run++; if ({we0, waddr0, wdata0} !== {1'b1, 6'd8, 32'h2}) begin n_fail++; $display("FAIL split0_second got %h", {we0, waddr0, wdata0}); end
    tick();
    @(negedge clk);
    n_run++; if ({we1, pend1, we0, pend0} !== 5'b0) begin n_fail++; $display("FAIL split_done got %b exp 0", {we1, pend1, we0, pend0}); end
    tick();
  endtask

  task automatic test_backpressure();
    logic       lsu_t [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       xv_t  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0] xrd_t [7] = '{6'd10, 6'd11, 6'd12, 6'd12, 6'd12, 6'd12, 6'd0};
    logic       rdy_t [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [5:0] adr_t [7] = '{6'd20, 6'd20, 6'd20, 6'd20, 6'd10, 6'd11, 6'd12};
    logic [31:0] exp_d;
    for (int c = 0; c < 7; c++) begin
      lsu_we = lsu_t[c]; lsu_waddr = 6'd20; lsu_wdata = 32'h5000 + c;
      if (xv_t[c]) drive_x(xrd_t[c], 1'b0, 1'b1, 32'h0, 32'h100 + {26'h0, xrd_t[c]});
      else clear_x();
      exp_d = lsu_t[c] ? 32'h5000 + c : 32'h100 + {26'h0, adr_t[c]};
      @(negedge clk);
      n_run++; if (ready1 !== rdy_t[c]) begin n_fail++; $display("FAIL bp_ready c%0d got %b exp %b", c, ready1, rdy_t[c]); end
      n_run++; if ({we1, waddr1, wdata1} !== {2'b01, adr_t[c], 32'h0, exp_d}) begin n_fail++; $display("FAIL bp_write c%0d got %h exp addr %0d data %h", c, {we1, waddr1, wdata1}, adr_t[c], exp_d); end
      n_run++; if ({ready0, we0, waddr0, wdata0} !== {rdy_t[c], 1'b1, adr_t[c], exp_d}) begin n_fail++; $display("FAIL bp_dut0 c%0d got %h", c, {ready0, we0, waddr0, wdata0}); end
      tick();
    end
    clear_x(); lsu_we = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    @(negedge clk);
    n_run++; if ({we1, pend1, ready1, we0, pend0} !== 5'b00100) begin n_fail++; $display("FAIL bp_drained got %b exp 00100", {we1, pend1, ready1, we0, pend0}); end
    tick();
  endtask

  task automatic test_illegal_drop();
    drive_x(6'd31, 1'b1, 1'b1, 32'h22, 32'h11);
    tick(); clear_x();
    @(negedge clk);
    n_run++; if ({we1, waddr1, wdata1, err1} !== {2'b01, 6'd31, 64'h11, 1'b1}) begin n_fail++; $display("FAIL ill31_write got %h", {we1, waddr1, wdata1, err1}); end
    n_run++; if ({we0, waddr0, err0} !== {1'b1, 6'd31, 1'b1}) begin n_fail++; $display("FAIL ill31_dut0 got %h", {we0, waddr0, err0}); end
    tick();
    @(negedge clk);
    n_run++; if ({we1, err1, pend1, we0, err0} !== 5'b0) begin n_fail++; $display("FAIL ill31_after got %b exp 0", {we1, err1, pend1, we0, err0}); end
    drive_x(6'd63, 1'b1, 1'b1, 32'h44, 32'h33);
    tick(); clear_x();
    @(negedge clk);
    n_run++; if ({we1, waddr1, wdata1, err1} !== {2'b01, 6'd63, 64'h33, 1'b1}) begin n_fail++; $display("FAIL ill63_write got %h", {we1, waddr1, wdata1, err1}); end
    tick();
    @(negedge clk);
    n_run++; if ({we1, err1, we0, err0, pend0} !== 5'b0) begin n_fail++; $display("FAIL ill63_after got %b exp 0", {we1, err1, we0, err0, pend0}); end
    drive_x(6'd4, 1'b0, 1'b0, 32'h0, 32'h77);
    tick(); clear_x();
    @(negedge clk);
    n_run++; if ({we1, pend1, we0, pend0} !== 5'b0) begin n_fail++; $display("FAIL drop_we0 got %b exp 0", {we1, pend1, we0, pend0}); end
    tick();
  endtask

  task automatic test_reset_mid_split();
    drive_x(6'd9, 1'b1, 1'b1, 32'hB, 32'hA);
    tick(); clear_x();
    @(negedge clk);
    n_run++; if ({we1, waddr1, wdata1} !== {2'b01, 6'd9, 64'hA}) begin n_fail++; $display("FAIL rst_first got %h", {we1, waddr1, wdata1}); end
    tick();
    rst_n = 1'b0;
    #1;
    n_run++; if ({we1, waddr1, wdata1, we0, waddr0, wdata0} !== 111'h0) begin n_fail++; $display("FAIL rst_outputs got %h exp 0", {we1, waddr1, wdata1, we0, waddr0, wdata0}); end
    n_run++; if ({ready1, pend1, ready0, pend0} !== 4'b1010) begin n_fail++; $display("FAIL rst_flags got %b exp 1010", {ready1, pend1, ready0, pend0}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      n_run++; if ({we1, we0, pend1, ready1} !== 5'b00001) begin n_fail++; $display("FAIL rst_no_second c%0d got %b exp 00001", c, {we1, we0, pend1, ready1}); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lsu_we = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    clear_x();
    test_reset();
    test_single();
    test_pair();
    test_split_lsu();
    test_backpressure();
    test_illegal_drop();
    test_reset_mid_split();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
